// File: rtl/mem_load_stage.sv
// mem_load_stage: MEM pipeline stage. Aligns load data (lb/lbu/lh/lhu/lw/lwl/lwr)
// from a DATA_W-bit response bus and waits for variable-latency responses.
// It parks a completed load while WB is stalled and drains the response of a
// flushed load. The WB-facing outputs are registered.
// Optional feature macro: MEM_LOAD_BYPASS_EN. When defined, the aligned load
// result is driven onto the bypass path in the cycle it becomes available.
module mem_load_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int MOP_W  = 10,
  localparam int AL    = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [31:0]       in_pc,
  input  logic              in_inslot,
  input  logic [MOP_W-1:0]  in_memop,
  input  logic [AL-1:0]     in_addr_low,
  input  logic              in_load,
  input  logic [REG_AW-1:0] in_waddr,
  input  logic [31:0]       in_wdata,
  input  logic [3:0]        in_wren,
  input  logic              in_nofwd,
  input  logic              in_mduinst,
  input  logic              flush,
  input  logic              ds_stall,
  input  logic              mdu_stallreq,
  input  logic              dresp_valid,
  input  logic [DATA_W-1:0] dresp_data,
  output logic              out_valid,
  output logic [31:0]       out_inst,
  output logic [31:0]       out_pc,
  output logic              out_inslot,
  output logic [REG_AW-1:0] out_waddr,
  output logic [31:0]       out_wdata,
  output logic [3:0]        out_wren,
  output logic              out_mduinst,
  output logic [31:0]       bp_wdata,
  output logic              bp_nofwd,
  output logic              stall_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_HOLD, ST_DRAIN} state_e;
  typedef enum logic [2:0] {LK_LB, LK_LBU, LK_LH, LK_LHU, LK_LW, LK_LWL, LK_LWR} ld_kind_e;

  // Instruction fields kept while a load waits for its response.
  typedef struct packed {
    logic [31:0]       inst;
    logic [31:0]       pc;
    logic              inslot;
    logic [REG_AW-1:0] waddr;
    ld_kind_e          kind;
    logic [AL-1:0]     addr_low;
    logic              mduinst;
  } pend_t;

  // One WB-side record; used for the output register and the hold buffer.
  typedef struct packed {
    logic              valid;
    logic [31:0]       inst;
    logic [31:0]       pc;
    logic              inslot;
    logic [REG_AW-1:0] waddr;
    logic [31:0]       wdata;
    logic [3:0]        wren;
    logic              mduinst;
  } wb_t;

  state_e   state_q, state_d;
  pend_t    pend_q, pend_d;
  wb_t      hold_q, wb_q;
  wb_t      in_rec, pend_rec, done_rec, commit_rec;
  ld_kind_e cur_kind;
  logic [AL-1:0] cur_addr;
  logic [31:0]   word, load_res;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [3:0]    load_wren;
  logic          accept, commit, pend_we, hold_we;

  // Store memop bits carry no meaning for this stage.
  logic unused_memop;
  assign unused_memop = ^in_memop[7:5];

  function automatic ld_kind_e decode_kind(input logic [MOP_W-1:0] mop);
    ld_kind_e k;
    k = LK_LW;
    if      (mop[0]) k = LK_LB;
    else if (mop[1]) k = LK_LBU;
    else if (mop[2]) k = LK_LH;
    else if (mop[3]) k = LK_LHU;
    else if (mop[8]) k = LK_LWL;
    else if (mop[9]) k = LK_LWR;
    return k;
  endfunction

  // A waiting load aligns with its captured fields; otherwise use the inputs.
  always_comb begin
    cur_kind = (state_q == ST_WAIT) ? pend_q.kind : decode_kind(in_memop);
    cur_addr = (state_q == ST_WAIT) ? pend_q.addr_low : in_addr_low;
  end

  if (DATA_W == 64) begin : g_lane64
    assign word = cur_addr[AL-1] ? dresp_data[DATA_W-1:32] : dresp_data[31:0];
  end else begin : g_lane32
    assign word = dresp_data[31:0];
  end

  // Byte/half extraction, extension and lwl/lwr byte-lane placement.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    byte_sel  = word[{cur_addr[1:0], 3'b000} +: 8];
    half_sel  = cur_addr[1] ? word[31:16] : word[15:0];
    load_res  = word;
    load_wren = 4'b1111;
    case (cur_kind)
      LK_LB:  load_res = {{24{byte_sel[7]}}, byte_sel};
      LK_LBU: load_res = {24'b0, byte_sel};
      LK_LH:  load_res = {{16{half_sel[15]}}, half_sel};
      LK_LHU: load_res = {16'b0, half_sel};
      LK_LWL: begin
        case (cur_addr[1:0])
          2'd0:    begin load_res = {word[7:0], 24'b0};  load_wren = 4'b1000; end
          2'd1:    begin load_res = {word[15:0], 16'b0}; load_wren = 4'b1100; end
          2'd2:    begin load_res = {word[23:0], 8'b0};  load_wren = 4'b1110; end
          default: begin load_res = word;                load_wren = 4'b1111; end
        endcase
      end
      LK_LWR: begin
        case (cur_addr[1:0])
          2'd0:    begin load_res = word;                load_wren = 4'b1111; end
          2'd1:    begin load_res = {8'b0, word[31:8]};  load_wren = 4'b0111; end
          2'd2:    begin load_res = {16'b0, word[31:16]}; load_wren = 4'b0011; end
          default: begin load_res = {24'b0, word[31:24]}; load_wren = 4'b0001; end
        endcase
      end
      default: load_res = word;
    endcase
  end

  // Candidate WB records from the inputs and from the pending load.
  always_comb begin
    in_rec         = '0;
    in_rec.valid   = 1'b1;
    in_rec.inst    = in_inst;
    in_rec.pc      = in_pc;
    in_rec.inslot  = in_inslot;
    in_rec.waddr   = in_waddr;
    in_rec.wdata   = in_load ? load_res : in_wdata;
    in_rec.wren    = in_load ? load_wren : in_wren;
    in_rec.mduinst = in_mduinst;

    pend_rec         = '0;
    pend_rec.valid   = 1'b1;
    pend_rec.inst    = pend_q.inst;
    pend_rec.pc      = pend_q.pc;
    pend_rec.inslot  = pend_q.inslot;
    pend_rec.waddr   = pend_q.waddr;
    pend_rec.wdata   = load_res;
    pend_rec.wren    = load_wren;
    pend_rec.mduinst = pend_q.mduinst;

    done_rec   = (state_q == ST_WAIT) ? pend_rec : in_rec;
    commit_rec = (state_q == ST_HOLD) ? hold_q : done_rec;

    pend_d          = '0;
    pend_d.inst     = in_inst;
    pend_d.pc       = in_pc;
    pend_d.inslot   = in_inslot;
    pend_d.waddr    = in_waddr;
    pend_d.kind     = decode_kind(in_memop);
    pend_d.addr_low = in_addr_low;
    pend_d.mduinst  = in_mduinst;
  end

  assign accept   = (state_q == ST_IDLE) && in_valid && !flush && !mdu_stallreq;
  assign stall_o  = mdu_stallreq || (state_q != ST_IDLE) ||
                    (in_valid && in_load && !dresp_valid);
  assign in_ready = !stall_o;

  // Next-state logic and commit/capture decisions.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    pend_we = 1'b0;
    hold_we = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!in_load) begin
            commit = 1'b1;
          end else if (!dresp_valid) begin
            pend_we = 1'b1;
            state_d = ST_WAIT;
          end else if (ds_stall) begin
            hold_we = 1'b1;
            state_d = ST_HOLD;
          end else begin
            commit = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (flush) begin
          state_d = dresp_valid ? ST_IDLE : ST_DRAIN;
        end else if (dresp_valid) begin
          if (ds_stall) begin
            hold_we = 1'b1;
            state_d = ST_HOLD;
          end else begin
            commit  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (!ds_stall) begin
          commit  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        if (dresp_valid) state_d = ST_IDLE;
      end
    endcase
  end

  // State, pending fields, hold buffer and WB output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      hold_q  <= '0;
      wb_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values regardless of statement order.
      state_q <= state_d;
      if (pend_we) pend_q <= pend_d;
      if (hold_we) hold_q <= done_rec;
      if (!ds_stall) wb_q <= (commit && !flush) ? commit_rec : '0;
    end
  end

  assign out_valid   = wb_q.valid;
  assign out_inst    = wb_q.inst;
  assign out_pc      = wb_q.pc;
  assign out_inslot  = wb_q.inslot;
  assign out_waddr   = wb_q.waddr;
  assign out_wdata   = wb_q.wdata;
  assign out_wren    = wb_q.wren;
  assign out_mduinst = wb_q.mduinst;

`ifdef MEM_LOAD_BYPASS_EN
  logic load_avail;
  // Forward the aligned result in the cycle it arrives; lwl/lwr need a merge.
  always_comb begin
    load_avail = (accept && in_load && dresp_valid) ||
                 ((state_q == ST_WAIT) && dresp_valid && !flush);
    bp_wdata   = load_avail ? load_res : in_wdata;
    bp_nofwd   = load_avail ? (in_nofwd || cur_kind == LK_LWL || cur_kind == LK_LWR)
                            : (in_nofwd || in_load);
  end
`else
  assign bp_wdata = in_wdata;
  assign bp_nofwd = in_nofwd || in_load;
`endif

endmodule

// File: tb/tb_mem_load_stage.sv
// Self-checking bench for mem_load_stage: a 32-bit instance checked through a
// scoreboard and a 64-bit instance checked inline for lane selection.
module tb_mem_load_stage;

  localparam logic [9:0] M_LB  = 10'h001, M_LBU = 10'h002, M_LH  = 10'h004;
  localparam logic [9:0] M_LHU = 10'h008, M_LW  = 10'h010, M_SW  = 10'h040;
  localparam logic [9:0] M_LWL = 10'h100, M_LWR = 10'h200;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        in_valid, in_inslot, in_load, in_nofwd, in_mduinst;
  logic        flush, ds_stall, mdu_stallreq, dresp_valid;
  logic [31:0] in_inst, in_pc, in_wdata;
  logic [9:0]  in_memop;
  logic [4:0]  in_waddr;
  logic [3:0]  in_wren;
  logic [1:0]  a32;
  logic [2:0]  a64;
  logic [31:0] d32;
  logic [63:0] d64;

  logic        in_ready, out_valid, out_inslot, out_mduinst, bp_nofwd, stall_o;
  logic [31:0] out_inst, out_pc, out_wdata, bp_wdata;
  logic [4:0]  out_waddr;
  logic [3:0]  out_wren;

  logic        r64, v64, is64, md64, nf64, st64;
  logic [31:0] i64, p64, w64, b64;
  logic [4:0]  wa64;
  logic [3:0]  we64;

  mem_load_stage #(.DATA_W(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .in_inslot(in_inslot), .in_memop(in_memop),
    .in_addr_low(a32), .in_load(in_load), .in_waddr(in_waddr), .in_wdata(in_wdata),
    .in_wren(in_wren), .in_nofwd(in_nofwd), .in_mduinst(in_mduinst), .flush(flush),
    .ds_stall(ds_stall), .mdu_stallreq(mdu_stallreq), .dresp_valid(dresp_valid),
    .dresp_data(d32), .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
    .out_inslot(out_inslot), .out_waddr(out_waddr), .out_wdata(out_wdata),
    .out_wren(out_wren), .out_mduinst(out_mduinst), .bp_wdata(bp_wdata),
    .bp_nofwd(bp_nofwd), .stall_o(stall_o));

  mem_load_stage #(.DATA_W(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r64),
    .in_inst(in_inst), .in_pc(in_pc), .in_inslot(in_inslot), .in_memop(in_memop),
    .in_addr_low(a64), .in_load(in_load), .in_waddr(in_waddr), .in_wdata(in_wdata),
    .in_wren(in_wren), .in_nofwd(in_nofwd), .in_mduinst(in_mduinst), .flush(flush),
    .ds_stall(ds_stall), .mdu_stallreq(mdu_stallreq), .dresp_valid(dresp_valid),
    .dresp_data(d64), .out_valid(v64), .out_inst(i64), .out_pc(p64),
    .out_inslot(is64), .out_waddr(wa64), .out_wdata(w64),
    .out_wren(we64), .out_mduinst(md64), .bp_wdata(b64),
    .bp_nofwd(nf64), .stall_o(st64));

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        inslot;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wren;
    logic        mduinst;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e, mon_a;
  bit   sb_on = 1'b1;
  logic out_upd = 1'b0;

  // The output register only reloads on edges where WB was not stalled.
  always @(posedge clk) out_upd <= !ds_stall;

  // Scoreboard: every freshly loaded valid output must match the oldest expectation.
  always @(negedge clk) begin
    if (sb_on && !rst && out_upd && out_valid) begin
      checks++;
      mon_a = {out_inst, out_pc, out_inslot, out_waddr, out_wdata, out_wren, out_mduinst};
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_unexpected: got inst=%h wdata=%h, required no output",
                 out_inst, out_wdata);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_a !== mon_e) begin
          errors++;
          $display("FAIL scoreboard: got inst=%h pc=%h waddr=%0d wdata=%h wren=%b, required inst=%h pc=%h waddr=%0d wdata=%h wren=%b",
                   mon_a.inst, mon_a.pc, mon_a.waddr, mon_a.wdata, mon_a.wren,
                   mon_e.inst, mon_e.pc, mon_e.waddr, mon_e.wdata, mon_e.wren);
        end
      end
    end
  end

  task automatic idle_inputs();
    in_valid = 0; in_inst = '0; in_pc = '0; in_inslot = 0; in_memop = '0;
    in_load = 0; in_waddr = '0; in_wdata = '0; in_wren = '0; in_nofwd = 0;
    in_mduinst = 0; flush = 0; mdu_stallreq = 0; dresp_valid = 0;
    a32 = '0; a64 = '0; d32 = '0; d64 = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic drive_load(input logic [9:0] mop, input logic [2:0] addr,
                            input logic [4:0] waddr, input logic [31:0] inst);
    in_valid = 1; in_load = 1; in_memop = mop; a64 = addr; a32 = addr[1:0];
    in_waddr = waddr; in_inst = inst; in_pc = inst ^ 32'h0040_0000;
    in_wdata = 32'h1111_1111;
  endtask

  task automatic drive_resp(input logic [63:0] data);
    dresp_valid = 1; d64 = data; d32 = data[31:0];
  endtask

  task automatic push_load(input logic [31:0] inst, input logic [4:0] waddr,
                           input logic [31:0] wdata, input logic [3:0] wren);
    sb_q.push_back({inst, inst ^ 32'h0040_0000, 1'b0, waddr, wdata, wren, 1'b0});
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    ds_stall = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, out_inst, out_pc, out_inslot, out_waddr, out_wdata, out_wren, out_mduinst} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b inst=%h wdata=%h wren=%b, required all zero",
               out_valid, out_inst, out_wdata, out_wren);
    end
    checks++;
    if (stall_o !== 1'b0 || in_ready !== 1'b1 || v64 !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall: got stall=%b ready=%b v64=%b, required 0 1 0", stall_o, in_ready, v64);
    end
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got valid=%b stall=%b, required 0 0", out_valid, stall_o);
    end
  endtask

  task automatic test_lb_same_cycle();
    next_cycle();
    drive_load(M_LB, 3'b011, 5'd3, 32'h8000_0003);
    drive_resp(64'h80AA_BBCC);
    push_load(32'h8000_0003, 5'd3, 32'hFFFF_FF80, 4'b1111);
    @(negedge clk);
    checks++;
    if (stall_o !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL lb_stall: got stall=%b ready=%b, required 0 1", stall_o, in_ready);
    end
    checks++;
`ifdef MEM_LOAD_BYPASS_EN
    if (bp_wdata !== 32'hFFFF_FF80 || bp_nofwd !== 1'b0) begin
      errors++;
      $display("FAIL lb_bypass: got %h/%b, required ffffff80/0", bp_wdata, bp_nofwd);
    end
`else
    if (bp_wdata !== 32'h1111_1111 || bp_nofwd !== 1'b1) begin
      errors++;
      $display("FAIL lb_bypass: got %h/%b, required 11111111/1", bp_wdata, bp_nofwd);
    end
`endif
    next_cycle();
    @(negedge clk);
    checks++;
    if (out_wdata !== 32'hFFFF_FF80 || out_wren !== 4'b1111 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL lb_result: got %h/%b stall=%b, required ffffff80/1111 stall=0",
               out_wdata, out_wren, stall_o);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL lb_bubble: got valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0]  mops[7]  = '{M_LBU, M_LH, M_LHU, M_LW, M_LB, M_LH, M_LBU};
    logic [1:0]  addrs[7] = '{2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3};
    logic [31:0] exps[7]  = '{32'h0000_00BB, 32'hFFFF_80AA, 32'h0000_BBCC,
                              32'h80AA_BBCC, 32'hFFFF_FFCC, 32'hFFFF_BBCC, 32'h0000_0080};
    for (int i = 0; i < 7; i++) begin
      next_cycle();
      drive_load(mops[i], {1'b0, addrs[i]}, 5'(i + 8), 32'h0100_0000 + 32'(i));
      drive_resp(64'h80AA_BBCC);
      push_load(32'h0100_0000 + 32'(i), 5'(i + 8), exps[i], 4'b1111);
      @(negedge clk);
      checks++;
      if (stall_o !== 1'b0) begin
        errors++;
        $display("FAIL b2b_stall[%0d]: got %b, required 0", i, stall_o);
      end
    end
    repeat (2) next_cycle();
  endtask

  task automatic test_lwl_lwr();
    logic [9:0]  mops[6]  = '{M_LWL, M_LWR, M_LWL, M_LWR, M_LWL, M_LWR};
    logic [1:0]  addrs[6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
    logic [31:0] exps[6]  = '{32'hCCDD_0000, 32'h0000_AABB, 32'hAABB_CCDD,
                              32'h0000_00AA, 32'hDD00_0000, 32'hAABB_CCDD};
    logic [3:0]  wrens[6] = '{4'b1100, 4'b0011, 4'b1111, 4'b0001, 4'b1000, 4'b1111};
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      drive_load(mops[i], {1'b0, addrs[i]}, 5'(i + 1), 32'h0200_0000 + 32'(i));
      drive_resp(64'hAABB_CCDD);
      push_load(32'h0200_0000 + 32'(i), 5'(i + 1), exps[i], wrens[i]);
      @(negedge clk);
      checks++;
      if (bp_nofwd !== 1'b1) begin
        errors++;
        $display("FAIL lwlr_nofwd[%0d]: got %b, required 1", i, bp_nofwd);
      end
    end
    repeat (2) next_cycle();
  endtask

  task automatic test_nonload();
    next_cycle();
    in_valid = 1; in_memop = M_SW; in_wdata = 32'h1234_5678; in_wren = 4'b0101;
    in_mduinst = 1; in_inslot = 1; in_inst = 32'h0300_0000; in_pc = 32'h0000_3000;
    in_waddr = 5'd9;
    sb_q.push_back({32'h0300_0000, 32'h0000_3000, 1'b1, 5'd9, 32'h1234_5678, 4'b0101, 1'b1});
    @(negedge clk);
    checks++;
    if (stall_o !== 1'b0 || bp_wdata !== 32'h1234_5678 || bp_nofwd !== 1'b0) begin
      errors++;
      $display("FAIL nonload_bypass: got stall=%b bp=%h nofwd=%b, required 0 12345678 0",
               stall_o, bp_wdata, bp_nofwd);
    end
    next_cycle();
    mdu_stallreq = 1;
    @(negedge clk);
    checks++;
    if (stall_o !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mdu_stall: got stall=%b ready=%b, required 1 0", stall_o, in_ready);
    end
    repeat (2) next_cycle();
  endtask

  task automatic test_wait_64();
    int stall_cnt = 0;
    logic [9:0]  mops[3]  = '{M_LW, M_LB, M_LH};
    logic [2:0]  addrs[3] = '{3'b000, 3'b101, 3'b100};
    logic [31:0] exps[3]  = '{32'h9ABC_DEF0, 32'h0000_0056, 32'h0000_5678};
    sb_on = 0;
    next_cycle();
    drive_load(M_LHU, 3'b110, 5'd4, 32'h0400_0000);
    @(negedge clk); stall_cnt += int'(st64);
    next_cycle();
    @(negedge clk); stall_cnt += int'(st64);
    next_cycle();
    drive_resp(64'h1234_5678_9ABC_DEF0);
    @(negedge clk); stall_cnt += int'(st64);
    next_cycle();
    @(negedge clk);
    checks++;
    if (stall_cnt != 3 || st64 !== 1'b0) begin
      errors++;
      $display("FAIL w64_stall: got %0d cycles (now %b), required 3 (now 0)", stall_cnt, st64);
    end
    checks++;
    if (v64 !== 1'b1 || w64 !== 32'h0000_1234 || we64 !== 4'b1111 || i64 !== 32'h0400_0000) begin
      errors++;
      $display("FAIL w64_result: got v=%b %h/%b inst=%h, required 1 00001234/1111 inst=04000000",
               v64, w64, we64, i64);
    end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      drive_load(mops[i], addrs[i], 5'd5, 32'h0500_0000);
      drive_resp(64'h1234_5678_9ABC_DEF0);
      next_cycle();
      @(negedge clk);
      checks++;
      if (v64 !== 1'b1 || w64 !== exps[i]) begin
        errors++;
        $display("FAIL lane64[%0d]: got v=%b %h, required 1 %h", i, v64, w64, exps[i]);
      end
    end
    repeat (2) next_cycle();
    sb_on = 1;
  endtask

  task automatic test_flush_drain();
    logic [5:0] stall_exp = 6'b001111;
    next_cycle();
    drive_load(M_LW, 3'b000, 5'd6, 32'h0600_0000);
    for (int c = 0; c < 6; c++) begin
      if (c == 1) flush = 1;
      if (c == 3) drive_resp(64'hDEAD_BEEF);
      @(negedge clk);
      checks++;
      if (stall_o !== stall_exp[c] || (c > 0 && out_valid !== 1'b0)) begin
        errors++;
        $display("FAIL drain_c%0d: got stall=%b valid=%b, required stall=%b valid=0",
                 c, stall_o, out_valid, stall_exp[c]);
      end
      next_cycle();
    end
  endtask

  task automatic test_hold();
    next_cycle();
    in_valid = 1; in_wdata = 32'hCAFE_0001; in_wren = 4'b1111; in_inst = 32'h0700_0000;
    in_pc = 32'h0000_7000; in_waddr = 5'd7;
    sb_q.push_back({32'h0700_0000, 32'h0000_7000, 1'b0, 5'd7, 32'hCAFE_0001, 4'b1111, 1'b0});
    next_cycle();
    drive_load(M_LH, 3'b000, 5'd10, 32'h0700_0001);
    ds_stall = 1;
    push_load(32'h0700_0001, 5'd10, 32'hFFFF_8001, 4'b1111);
    next_cycle();
    drive_resp(64'h0000_8001);
    for (int c = 2; c < 5; c++) begin
      if (c == 4) ds_stall = 0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_wdata !== 32'hCAFE_0001 || stall_o !== 1'b1) begin
        errors++;
        $display("FAIL hold_c%0d: got valid=%b wdata=%h stall=%b, required 1 cafe0001 1",
                 c, out_valid, out_wdata, stall_o);
      end
      next_cycle();
      if (c < 3) ds_stall = 1;
    end
    @(negedge clk);
    checks++;
    if (out_wdata !== 32'hFFFF_8001 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL hold_commit: got %h stall=%b, required ffff8001 stall=0", out_wdata, stall_o);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_once: got valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_hold_flush();
    next_cycle();
    drive_load(M_LW, 3'b000, 5'd11, 32'h0800_0000);
    next_cycle();
    drive_resp(64'h0BAD_F00D);
    ds_stall = 1;
    next_cycle();
    flush = 1;
    @(negedge clk);
    checks++;
    if (stall_o !== 1'b1) begin
      errors++;
      $display("FAIL hflush_hold: got stall=%b, required 1", stall_o);
    end
    next_cycle();
    ds_stall = 0;
    @(negedge clk);
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("FAIL hflush_idle: got stall=%b, required 0", stall_o);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hflush_drop: got valid=%b wdata=%h, required 0", out_valid, out_wdata);
    end
  endtask

  task automatic test_reset_in_wait();
    next_cycle();
    in_valid = 1; in_wdata = 32'h7777_0002; in_wren = 4'b0011; in_inst = 32'h0900_0000;
    in_pc = 32'h0000_9000; in_waddr = 5'd12;
    sb_q.push_back({32'h0900_0000, 32'h0000_9000, 1'b0, 5'd12, 32'h7777_0002, 4'b0011, 1'b0});
    next_cycle();
    drive_load(M_LW, 3'b000, 5'd13, 32'h0900_0001);
    ds_stall = 1;
    next_cycle();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || stall_o !== 1'b1) begin
      errors++;
      $display("FAIL rwait_pre: got valid=%b stall=%b, required 1 1", out_valid, stall_o);
    end
    #1 rst = 1;
    #1;
    checks++;
    if ({out_valid, out_inst, out_pc, out_waddr, out_wdata, out_wren} !== '0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL rwait_reset: got valid=%b wdata=%h stall=%b, required 0 0 0",
               out_valid, out_wdata, stall_o);
    end
    next_cycle();
    rst = 0; ds_stall = 0;
    drive_resp(64'h5555_AAAA);
    @(negedge clk);
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("FAIL rwait_late: got stall=%b, required 0", stall_o);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rwait_ignored: got valid=%b wdata=%h, required 0", out_valid, out_wdata);
    end
  endtask

  initial begin
    test_reset();
    test_lb_same_cycle();
    test_back_to_back();
    test_lwl_lwr();
    test_nonload();
    test_wait_64();
    test_flush_drain();
    test_hold();
    test_hold_flush();
    test_reset_in_wait();
    repeat (3) next_cycle();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d outstanding, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_load_stage.md
Name: mem_load_stage

Overview:
Parametrised successor to the MEM pipeline stage of the MIPS32 core. It aligns load data for lb/lbu/lh/lhu/lw/lwl/lwr from a data bus of DATA_W bits and waits for a variable-latency data response through a FSM. It also holds a completed load while the downstream stage is stalled, and drops the response to a flushed load. Sits between EX/address stage and WB; the WB-facing outputs are registered.

Parameters:
DATA_W, 32, data response bus width; legal 32 or 64; AL = log2(DATA_W/8) address-low bits.
REG_AW, 5, register-file address width.
MOP_W, 10, one-hot memop width; bit0 lb, 1 lbu, 2 lh, 3 lhu, 4 lw, 5-7 stores, 8 lwl, 9 lwr.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  instruction present
in_ready  out  1  stage accepts instruction; equals ~stall_o
in_inst / in_pc  in  32 each  instruction word and PC
in_inslot  in  1  delay-slot flag
in_memop  in  MOP_W  one-hot memop
in_addr_low  in  AL  low address bits of the access
in_load  in  1  instruction is a load (any of bits 0-4, 8, 9)
in_waddr  in  REG_AW  destination register
in_wdata  in  32  non-load result, and the old rt value for lwl/lwr merge
in_wren  in  4  byte write enables for non-load
in_nofwd  in  1  result not forwardable
in_mduinst  in  1  MDU instruction flag
flush  in  1  kill instruction in stage
ds_stall  in  1  downstream (WB) stall
mdu_stallreq  in  1  MDU second-stage stall request
dresp_valid  in  1  data response valid
dresp_data  in  DATA_W  response data
out_valid, out_inst, out_pc, out_inslot, out_waddr, out_wdata(32), out_wren(4), out_mduinst  out  —  registered WB-side copies
bp_wdata  out  32  bypass data
bp_nofwd  out  1  bypass not permitted
stall_o  out  1  stall request to upstream

Behaviour:
- Reset: FSM=IDLE; all out_* = 0; hold buffer cleared. stall_o, bp_* are combinational and follow the rules below.
- Lane select:
  - For DATA_W=64, word = dresp_data[63:32] if in_addr_low[2] else [31:0].
  - Byte/half selection then uses addr_low[1:0].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw returns the word.
- lwl, by addr_low[1:0] 0..3:
  - result {w[7:0],24'b0}, {w[15:0],16'b0}, {w[23:0],8'b0}, w.
  - wren 1000, 1100, 1110, 1111.
- lwr, by addr_low[1:0] 0..3:
  - result w, {8'b0,w[31:8]}, {16'b0,w[31:16]}, {24'b0,w[31:24]}.
  - wren 1111, 0111, 0011, 0001.
- Non-loads: out_wdata = in_wdata, out_wren = in_wren.
- FSM states:
  - IDLE:
    - in_valid & in_load & ~dresp_valid & ~flush → WAIT; instruction fields captured into pending register.
    - Load with dresp_valid in the same cycle completes with zero extra latency.
  - WAIT: dresp_valid & ~flush →
    - If ~ds_stall: commit to out_*, go to IDLE.
    - Else: write to hold buffer, go to HOLD.
  - HOLD: stays until ~ds_stall; then commit hold buffer, go to IDLE.
  - DRAIN: entered on flush in WAIT without dresp_valid; next dresp_valid is discarded, then go to IDLE. Flush in DRAIN stays in DRAIN.
- stall_o = mdu_stallreq | state∈{WAIT,HOLD,DRAIN} | (IDLE & in_valid & in_load & ~dresp_valid).
- Output register load enable = ~ds_stall. When enabled with no commit, or with flush, out_* load a bubble (all zero, out_valid=0). flush in WAIT with dresp_valid the same cycle: response dropped, go to IDLE.
- Flush in HOLD: hold buffer discarded, go to IDLE.
- Only one outstanding load; in_ready=0 blocks new issue.

Optional Feature:
MEM_LOAD_BYPASS_EN.
- Defined: in the cycle a load result becomes available (IDLE zero-latency or WAIT with dresp_valid), bp_wdata = aligned load result and bp_nofwd = in_nofwd. lwl/lwr are always nofwd.
- Undefined: bp_wdata = in_wdata, bp_nofwd = in_nofwd | in_load.

Test Plan:
- DATA_W=32: lb, addr_low=2'b11, dresp_data=32'h80AA_BBCC in the same cycle → next cycle out_wdata=32'hFFFF_FF80, wren=1111, stall_o never high.
- DATA_W=64: lhu, addr_low=3'b110, response 3 cycles late with data 64'h1234_5678_9ABC_DEF0 → stall_o high 3 cycles; out_wdata=32'h0000_1234.
- lwl, addr_low=01, in_wdata=32'h1111_1111, resp 32'hAABB_CCDD → out_wdata=32'hCCDD_0000, wren=1100; lwr, addr_low=10 → 32'h0000_AABB, wren=0011.
- Load waiting, flush at cycle 1, response at cycle 3 with 32'hDEAD_BEEF → DRAIN, response discarded, out_valid=0, stall_o low from cycle 4.
- Response arrives while ds_stall=1 for 2 cycles → HOLD; out_* unchanged until ds_stall falls, then the correct value is committed exactly once.
- rst asserted while in WAIT → out_* = 0 immediately, FSM=IDLE; a late dresp_valid is ignored.
